// File: rtl/out_seq_pkg.sv
// Shared state encoding and bank geometry for the bank output sequencer.
package out_seq_pkg;

    localparam int unsigned NUM_BANKS = 16;
    localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/bank_out_sequencer_fifo.sv
// Synchronous FIFO with registered storage; head is the word at the read pointer.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/define.svh
// Project-wide data width for the banked memory datapath.
`ifndef DEFINE_SVH
`define DEFINE_SVH
`define D_width 16
`endif

// File: rtl/bank_out_sequencer.sv
// Sweeps a contiguous word range across 16 interleaved SRAM banks and streams
// the words out through a credit-limited FIFO with valid/ready handshake.
`include "define.svh"

module bank_out_sequencer #(
    parameter int unsigned AW = 6,
    parameter int unsigned FD = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AW+3:0]       base_word,
    input  logic [AW+4:0]       num_words,
    output logic                mem_re,
    output logic [AW-1:0]       mem_addr,
    output logic [4:0]          sel_out,
    input  logic [`D_width-1:0] Q_out,
    output logic [`D_width-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);
    import out_seq_pkg::*;

    localparam int unsigned CW = $clog2(FD) + 1;
    localparam int unsigned SW = CW + 1;
    localparam logic [AW+4:0] LAST_WORD = 1;

    seq_state_t           state_q, state_d;
    logic [AW+3:0]        word_q, word_d;
    logic [AW+4:0]        remaining_q, remaining_d;
    logic                 inflight_q, inflight_d;
    logic [BANK_BITS-1:0] sel_q, sel_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [CW-1:0]        fifo_count;
    logic                 pop;
    logic                 credit_ok;
    logic                 issue;

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    // Credits count words already queued plus the one returning from SRAM;
    // a same-cycle pop is deliberately not credited back.
    assign credit_ok = ({1'b0, fifo_count} + SW'(inflight_q)) < SW'(FD);
    assign issue     = (state_q == ISSUE) && credit_ok;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        remaining_d = remaining_q;
        inflight_d  = 1'b0;
        sel_d       = sel_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        state_d     = ISSUE;
                        word_d      = base_word;
                        remaining_d = num_words;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    inflight_d  = 1'b1;
                    sel_d       = word_q[BANK_BITS-1:0];
                    word_d      = word_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LAST_WORD) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q &&
                    ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_re   = issue;
    assign mem_addr = word_q[AW+3:BANK_BITS];
    assign sel_out  = {1'b0, sel_q};
    assign busy     = busy_q;
    assign done     = done_q;

    sync_fifo #(
        .WIDTH (`D_width),
        .DEPTH (FD)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (Q_out),
        .pop       (pop),
        .count     (fifo_count),
        .head      (out_data)
    );

endmodule
